// File: rtl/reorder_pkg.sv
// Shared types and constants for the double-buffered reorder FIFO (write and read sides).
package reorder_pkg;

    localparam int DEFAULT_DEPTH = 16;

    localparam int WR0_BIT    = 0;
    localparam int WR1_BIT    = 1;
    localparam int WRWAIT_BIT = 2;

    typedef enum logic [2:0] {
        WR0    = 3'b001,
        WR1    = 3'b010,
        WRWAIT = 3'b100
    } wr_state_t;

endpackage

// File: rtl/wr_fsm_slot_tracker.sv
// Per-bank slot bitmap: records written slots, flags duplicates and detects the final fill.
module slot_tracker
    import reorder_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          accept,
    input  logic [AW-1:0] idx,
    output logic          dup,
    output logic          complete
);

    logic [DEPTH-1:0] bitmap;
    logic [DEPTH-1:0] hit;

    always_comb begin
        hit      = '0;
        hit[idx] = 1'b1;
        dup      = accept & bitmap[idx];
        complete = accept & ~dup & (&(bitmap | hit));
    end

    // Completion empties the map so the next bank starts clean on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
        end else if (clear || complete) begin
            bitmap <= '0;
        end else if (accept && !dup) begin
            bitmap <= bitmap | hit;
        end
    end

endmodule

// File: rtl/wr_fsm.sv
// Write-side bank controller of the reorder FIFO: steers tagged entries into the filling bank.
module wr_fsm
    import reorder_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_idx,
    output logic          wr_ready,
    output logic          mem0_we,
    output logic          mem1_we,
    output logic [AW-1:0] mem_waddr,
    output logic          mem0_lock,
    output logic          mem1_lock,
    input  logic          mem0_empty,
    input  logic          mem1_empty,
    output logic          dup_err
);

    wr_state_t state;
    wr_state_t state_nxt;

    logic filling0;
    logic filling1;
    logic accept;
    logic dup;
    logic complete;
    logic free0;
    logic free1;

    slot_tracker #(
        .DEPTH (DEPTH)
    ) u_slot_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (~(filling0 | filling1)),
        .accept   (accept),
        .idx      (wr_idx),
        .dup      (dup),
        .complete (complete)
    );

    always_comb begin
        filling0  = (state == WR0);
        filling1  = (state == WR1);
        // rst_n gates ready so no transfer is signalled while reset is held.
        wr_ready  = rst_n & (filling0 | filling1);
        accept    = wr_valid & wr_ready;
        mem0_we   = accept & filling0 & ~dup;
        mem1_we   = accept & filling1 & ~dup;
        mem_waddr = wr_idx;
        free0     = ~mem0_lock | mem0_empty;
        free1     = ~mem1_lock | mem1_empty;

        state_nxt = state;
        case (state)
            WR0: begin
                if (complete) state_nxt = free1 ? WR1 : WRWAIT;
            end
            WR1: begin
                if (complete) state_nxt = free0 ? WR0 : WRWAIT;
            end
            WRWAIT: begin
                if (free0)      state_nxt = WR0;
                else if (free1) state_nxt = WR1;
            end
            default: state_nxt = WRWAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WR0;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_lock <= 1'b0;
            mem1_lock <= 1'b0;
            dup_err   <= 1'b0;
        end else begin
            dup_err <= dup;
            if (complete && filling0)            mem0_lock <= 1'b1;
            else if (mem0_lock && mem0_empty)    mem0_lock <= 1'b0;
            if (complete && filling1)            mem1_lock <= 1'b1;
            else if (mem1_lock && mem1_empty)    mem1_lock <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wr_fsm.sv
// Directed vector bench for wr_fsm with DEPTH=4.
module tb_wr_fsm;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    // {valid, idx, e0, e1 | ready, we0, we1, lock0, lock1, dup_err}
    typedef struct packed {
        logic          valid;
        logic [AW-1:0] idx;
        logic          e0;
        logic          e1;
        logic          ready;
        logic          we0;
        logic          we1;
        logic          lock0;
        logic          lock1;
        logic          dup;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [AW-1:0] wr_idx;
    logic          wr_ready;
    logic          mem0_we;
    logic          mem1_we;
    logic [AW-1:0] mem_waddr;
    logic          mem0_lock;
    logic          mem1_lock;
    logic          mem0_empty;
    logic          mem1_empty;
    logic          dup_err;

    int vectors     = 0;
    int miscompares = 0;

    vec_t vecs [27];

    wr_fsm #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_idx     (wr_idx),
        .wr_ready   (wr_ready),
        .mem0_we    (mem0_we),
        .mem1_we    (mem1_we),
        .mem_waddr  (mem_waddr),
        .mem0_lock  (mem0_lock),
        .mem1_lock  (mem1_lock),
        .mem0_empty (mem0_empty),
        .mem1_empty (mem1_empty),
        .dup_err    (dup_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        wr_valid   = v.valid;
        wr_idx     = v.idx;
        mem0_empty = v.e0;
        mem1_empty = v.e1;
    endtask

    task automatic check(input string name, input vec_t e);
        vec_t act;
        act = '{valid: wr_valid, idx: mem_waddr, e0: mem0_empty, e1: mem1_empty,
                ready: wr_ready, we0: mem0_we, we1: mem1_we,
                lock0: mem0_lock, lock1: mem1_lock, dup: dup_err};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got v/idx/e0e1/rdy/we0we1/lk0lk1/dup=%b_%b_%b%b_%b_%b%b_%b%b_%b want %b_%b_%b%b_%b_%b%b_%b%b_%b",
                     name, act.valid, act.idx, act.e0, act.e1, act.ready, act.we0, act.we1,
                     act.lock0, act.lock1, act.dup, e.valid, e.idx, e.e0, e.e1, e.ready,
                     e.we0, e.we1, e.lock0, e.lock1, e.dup);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(name, v);
    endtask

    initial begin
        // fill bank 0 out of order
        vecs[0]  = 11'b1_10_00_1_10_00_0;
        vecs[1]  = 11'b1_00_00_1_10_00_0;
        vecs[2]  = 11'b1_11_00_1_10_00_0;
        vecs[3]  = 11'b1_01_00_1_10_00_0;
        // fill bank 1 while bank 0 is still unread -> WRWAIT
        vecs[4]  = 11'b1_00_00_1_01_10_0;
        vecs[5]  = 11'b1_01_00_1_01_10_0;
        vecs[6]  = 11'b1_10_00_1_01_10_0;
        vecs[7]  = 11'b1_11_00_1_01_10_0;
        vecs[8]  = 11'b1_00_00_0_00_11_0;
        vecs[9]  = 11'b1_00_10_0_00_11_0;
        vecs[10] = 11'b1_00_00_1_10_01_0;
        // duplicate idx 1, then finish bank 0 while bank 1 drains on the same edge
        vecs[11] = 11'b1_01_00_1_10_01_0;
        vecs[12] = 11'b1_01_00_1_00_01_0;
        vecs[13] = 11'b1_10_00_1_10_01_1;
        vecs[14] = 11'b1_11_01_1_10_01_0;
        // fill bank 1, completing as bank 0 drains: no WRWAIT
        vecs[15] = 11'b1_00_00_1_01_10_0;
        vecs[16] = 11'b1_01_00_1_01_10_0;
        vecs[17] = 11'b1_10_00_1_01_10_0;
        vecs[18] = 11'b1_11_10_1_01_10_0;
        vecs[19] = 11'b0_00_00_1_00_01_0;
        // fill bank 0 with bank 1 locked -> WRWAIT, then both drain together
        vecs[20] = 11'b1_11_00_1_10_01_0;
        vecs[21] = 11'b1_10_00_1_10_01_0;
        vecs[22] = 11'b1_01_00_1_10_01_0;
        vecs[23] = 11'b1_00_00_1_10_01_0;
        vecs[24] = 11'b0_00_00_0_00_11_0;
        vecs[25] = 11'b1_10_11_0_00_11_0;
        vecs[26] = 11'b1_10_00_1_10_00_0;

        rst_n = 1'b0;
        drive(11'b1_00_00_0_00_00_0);
        #12;
        check("in_reset", 11'b1_00_00_0_00_00_0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(11'b0_00_00_0_00_00_0);
        #1;
        check("after_reset", 11'b0_00_00_1_00_00_0);

        for (int i = 0; i < 27; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // bank 0 now holds slot 2; add slot 0, then reset mid-write
        step("pre_rst_w0", 11'b1_00_00_1_10_00_0);
        @(negedge clk);
        drive(11'b1_01_00_0_00_00_0);
        #1;
        check("pre_rst_w1", 11'b1_01_00_1_10_00_0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", 11'b1_01_00_0_00_00_0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(11'b0_00_00_0_00_00_0);
        #1;
        check("rst_release", 11'b0_00_00_1_00_00_0);

        // all four slots must be written again before the lock
        step("refill0", 11'b1_00_00_1_10_00_0);
        step("refill1", 11'b1_01_00_1_10_00_0);
        step("refill2", 11'b1_10_00_1_10_00_0);
        step("refill_idle", 11'b0_00_00_1_00_00_0);
        step("refill3", 11'b1_11_00_1_10_00_0);
        step("refill_lock", 11'b0_00_00_1_00_10_0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
